byte_demux_quad: RTL

Sequential 1-to-4 byte distributor, the write-side counterpart of the four-input byte multiplexer cell in the WSN-SoC cell library. Captures a byte on a strobe and steers it into one of four holding registers. The target is chosen either by select bits, using the same priority order as the mux (D over C over A/B), or by an internal auto-incrementing pointer. Used where reconfigurable logic must scatter a byte stream into four parallel byte consumers, and needs a per-output write strobe and a "all four written" flag.

---
 rtl/byte_demux_quad.sv | 117 +++++++++++
 1 files changed

// File: rtl/byte_demux_quad.sv
// Sequential 1-to-4 byte distributor: steers a strobed byte into one of four holding registers.
// Optional pointer-driven targeting is built when BYTEDEMUXQUAD_AUTOINC_EN is defined.
module byte_demux_quad #(
    parameter logic [7:0] ResetValue = 8'h00
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic [7:0] Data_i,
    input  logic       Strobe_i,
    input  logic       SAB_i,
    input  logic       SC_i,
    input  logic       SD_i,
    input  logic       Auto_i,
    input  logic       Clear_i,
    output logic [7:0] A_o,
    output logic [7:0] B_o,
    output logic [7:0] C_o,
    output logic [7:0] D_o,
    output logic       StrobeA_o,
    output logic       StrobeB_o,
    output logic       StrobeC_o,
    output logic       StrobeD_o,
    output logic       Full_o,
    output logic [1:0] Ptr_o
);

    logic [1:0] manual_sel;
    logic [1:0] target;
    logic [3:0] target_onehot;
    logic [3:0] mask;
    logic [3:0] mask_next;
    logic       accept;

    // Same priority order as the four-input mux: D over C over A/B.
    always_comb begin
        manual_sel = 2'd0;
        if (SD_i) begin
            manual_sel = 2'd3;
        end else if (SC_i) begin
            manual_sel = 2'd2;
        end else if (SAB_i) begin
            manual_sel = 2'd1;
        end
    end

    assign accept = Strobe_i & ~Clear_i;

`ifdef BYTEDEMUXQUAD_AUTOINC_EN
    logic [1:0] ptr;

    assign target = Auto_i ? ptr : manual_sel;
    assign Ptr_o  = ptr;

    // Pointer only moves on accepted auto-mode writes; 2-bit add wraps 3 -> 0.
    always_ff @(posedge Clk_i) begin
        if (Reset_i || Clear_i) begin
            ptr <= 2'd0;
        end else if (accept && Auto_i) begin
            ptr <= ptr + 2'd1;
        end
    end
`else
    logic unused_auto;

    assign unused_auto = Auto_i;
    assign target      = manual_sel;
    assign Ptr_o       = 2'b00;
`endif

    always_comb begin
        target_onehot = 4'b0000;
        target_onehot[target] = 1'b1;
    end

    assign mask_next = mask | target_onehot;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            A_o       <= ResetValue;
            B_o       <= ResetValue;
            C_o       <= ResetValue;
            D_o       <= ResetValue;
            StrobeA_o <= 1'b0;
            StrobeB_o <= 1'b0;
            StrobeC_o <= 1'b0;
            StrobeD_o <= 1'b0;
            mask      <= 4'b0000;
            Full_o    <= 1'b0;
        end else if (Clear_i) begin
            StrobeA_o <= 1'b0;
            StrobeB_o <= 1'b0;
            StrobeC_o <= 1'b0;
            StrobeD_o <= 1'b0;
            mask      <= 4'b0000;
            Full_o    <= 1'b0;
        end else begin
            StrobeA_o <= accept & target_onehot[0];
            StrobeB_o <= accept & target_onehot[1];
            StrobeC_o <= accept & target_onehot[2];
            StrobeD_o <= accept & target_onehot[3];
            if (accept) begin
                case (target)
                    2'd0:    A_o <= Data_i;
                    2'd1:    B_o <= Data_i;
                    2'd2:    C_o <= Data_i;
                    default: D_o <= Data_i;
                endcase
                mask <= mask_next;
                // Sticky until clear/reset, so rewrites never drop it.
                if (mask_next == 4'b1111) begin
                    Full_o <= 1'b1;
                end
            end
        end
    end

endmodule
